uart_host_ctrl: RTL and testbench

//  Bus initiator that drives the UART register slave (uart_regs) through its
//  8-bit register port. Programs divisor/LCR/FCR/IER on request, streams TX

---
 rtl/uart_host_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_host_ctrl.sv | 541 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_ctrl.sv
// Bus initiator for the UART register slave: runs the configuration sequence,
// streams TX bytes into THR under a credit scheme and services the UART
// interrupt by reading IIR followed by RB, LSR or MSR.
module uart_host_ctrl #(
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned INT_SETTLE = 2
) (
    input  logic              clk,
    input  logic              wb_rst_n,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [7:0]        wb_dat_o,
    output logic              wb_we_o,
    output logic              wb_re_o,
    input  logic [7:0]        wb_dat_i,
    input  logic              int_i,
    input  logic              cfg_start,
    input  logic [15:0]       cfg_div,
    input  logic [6:0]        cfg_lcr,
    input  logic [7:0]        cfg_fcr,
    input  logic [3:0]        cfg_ier,
    output logic              cfg_done,
    output logic              busy,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [7:0]        lsr_o,
    output logic              lsr_stb,
    output logic [7:0]        msr_o,
    output logic              msr_stb
);

    localparam int unsigned CredW = $clog2(TX_DEPTH + 1);
    localparam int unsigned SetW  = (INT_SETTLE > 1) ? $clog2(INT_SETTLE) : 1;

    localparam logic [CredW-1:0]  CredFull = CredW'(TX_DEPTH);
    localparam logic [ADDR_W-1:0] AddrTr   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] AddrIe   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AddrFcIi = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] AddrLc   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] AddrLs   = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] AddrMs   = ADDR_W'(6);

    typedef enum logic [3:0] {
        StIdle, StCfgWr, StCfgGap, StTxGap, StIirRd, StIirWait, StLsrRd, StLsrWait,
        StMsrRd, StMsrWait, StRbRd, StRbWait, StRxHold, StSettle
    } state_e;

    // Every INT service ends here; with no settle time go straight back to idle.
    localparam state_e           SettleEntry = (INT_SETTLE == 0) ? StIdle : StSettle;
    localparam logic [SetW-1:0]  SettleInit  =
        SetW'((INT_SETTLE == 0) ? 0 : INT_SETTLE - 1);

    state_e            state_q, state_d;
    logic [2:0]        cfg_idx_q, cfg_idx_d;
    logic [15:0]       div_q, div_d;
    logic [6:0]        lcr_q, lcr_d;
    logic [7:0]        fcr_q, fcr_d;
    logic [3:0]        ier_q, ier_d;
    logic              configured_q, configured_d;
    logic [CredW-1:0]  credits_q, credits_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [7:0]        lsr_q, lsr_d;
    logic              lsr_stb_q, lsr_stb_d;
    logic [7:0]        msr_q, msr_d;
    logic              msr_stb_q, msr_stb_d;

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!wb_rst_n) begin
            state_q      <= StIdle;
            cfg_idx_q    <= '0;
            div_q        <= '0;
            lcr_q        <= '0;
            fcr_q        <= '0;
            ier_q        <= '0;
            configured_q <= 1'b0;
            credits_q    <= '0;
            settle_q     <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            lsr_q        <= '0;
            lsr_stb_q    <= 1'b0;
            msr_q        <= '0;
            msr_stb_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_idx_q    <= cfg_idx_d;
            div_q        <= div_d;
            lcr_q        <= lcr_d;
            fcr_q        <= fcr_d;
            ier_q        <= ier_d;
            configured_q <= configured_d;
            credits_q    <= credits_d;
            settle_q     <= settle_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            lsr_q        <= lsr_d;
            lsr_stb_q    <= lsr_stb_d;
            msr_q        <= msr_d;
            msr_stb_q    <= msr_stb_d;
        end
    end

    // Next-state, register updates and bus outputs.
    always_comb begin
        state_d      = state_q;
        cfg_idx_d    = cfg_idx_q;
        div_d        = div_q;
        lcr_d        = lcr_q;
        fcr_d        = fcr_q;
        ier_d        = ier_q;
        configured_d = configured_q;
        credits_d    = credits_q;
        settle_d     = settle_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        lsr_d        = lsr_q;
        lsr_stb_d    = 1'b0;
        msr_d        = msr_q;
        msr_stb_d    = 1'b0;
        wb_addr_o    = '0;
        wb_dat_o     = '0;
        wb_we_o      = 1'b0;
        wb_re_o      = 1'b0;
        cfg_done     = 1'b0;
        tx_ready     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Settle time is spent in StSettle, so the counter is always 0 here.
                if (cfg_start) begin
                    div_d     = cfg_div;
                    lcr_d     = cfg_lcr;
                    fcr_d     = cfg_fcr;
                    ier_d     = cfg_ier;
                    cfg_idx_d = 3'd0;
                    state_d   = StCfgWr;
                end else if (configured_q && int_i) begin
                    state_d = StIirRd;
                end else if (configured_q && tx_valid && (credits_q != '0)) begin
                    // THR write issues straight from idle so the byte is taken this cycle.
                    wb_we_o   = 1'b1;
                    wb_addr_o = AddrTr;
                    wb_dat_o  = tx_data;
                    tx_ready  = 1'b1;
                    credits_d = credits_q - CredW'(1);
                    state_d   = StTxGap;
                end
            end
            StCfgWr: begin
                wb_we_o = 1'b1;
                unique case (cfg_idx_q)
                    3'd0: begin wb_addr_o = AddrLc;   wb_dat_o = {1'b1, lcr_q};  end
                    3'd1: begin wb_addr_o = AddrTr;   wb_dat_o = div_q[7:0];     end
                    3'd2: begin wb_addr_o = AddrIe;   wb_dat_o = div_q[15:8];    end
                    3'd3: begin wb_addr_o = AddrLc;   wb_dat_o = {1'b0, lcr_q};  end
                    3'd4: begin wb_addr_o = AddrFcIi; wb_dat_o = fcr_q;          end
                    3'd5: begin wb_addr_o = AddrIe;   wb_dat_o = {4'b0, ier_q};  end
                    default: begin wb_addr_o = '0;    wb_dat_o = '0;             end
                endcase
                if (cfg_idx_q == 3'd5) begin
                    cfg_done     = 1'b1;
                    configured_d = 1'b1;
                    credits_d    = CredFull;
                end
                state_d = StCfgGap;
            end
            StCfgGap: begin
                if (cfg_idx_q == 3'd5) begin
                    state_d = StIdle;
                end else begin
                    cfg_idx_d = cfg_idx_q + 3'd1;
                    state_d   = StCfgWr;
                end
            end
            StTxGap: state_d = StIdle;
            StIirRd: begin
                wb_re_o   = 1'b1;
                wb_addr_o = AddrFcIi;
                state_d   = StIirWait;
            end
            StIirWait: begin
                // IIR data is valid this cycle; bit 0 set means nothing pending.
                state_d  = SettleEntry;
                settle_d = SettleInit;
                if (!wb_dat_i[0]) begin
                    unique case (wb_dat_i[3:1])
                        3'b011:         state_d = StLsrRd;
                        3'b010, 3'b110: state_d = StRbRd;
                        3'b001:         credits_d = CredFull;
                        3'b000:         state_d = StMsrRd;
                        default:        state_d = SettleEntry;
                    endcase
                end
            end
            StLsrRd: begin
                wb_re_o   = 1'b1;
                wb_addr_o = AddrLs;
                state_d   = StLsrWait;
            end
            StLsrWait: begin
                lsr_d     = wb_dat_i;
                lsr_stb_d = 1'b1;
                state_d   = SettleEntry;
                settle_d  = SettleInit;
            end
            StMsrRd: begin
                wb_re_o   = 1'b1;
                wb_addr_o = AddrMs;
                state_d   = StMsrWait;
            end
            StMsrWait: begin
                msr_d     = wb_dat_i;
                msr_stb_d = 1'b1;
                state_d   = SettleEntry;
                settle_d  = SettleInit;
            end
            StRbRd: begin
                wb_re_o   = 1'b1;
                wb_addr_o = AddrTr;
                state_d   = StRbWait;
            end
            StRbWait: begin
                rx_data_d  = wb_dat_i;
                rx_valid_d = 1'b1;
                state_d    = StRxHold;
            end
            StRxHold: begin
                // No bus traffic until the consumer takes the byte.
                if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    state_d    = SettleEntry;
                    settle_d   = SettleInit;
                end
            end
            StSettle: begin
                if (settle_q == '0) begin
                    state_d = StIdle;
                end else begin
                    settle_d = settle_q - SetW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign lsr_o    = lsr_q;
    assign lsr_stb  = lsr_stb_q;
    assign msr_o    = msr_q;
    assign msr_stb  = msr_stb_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed self-checking bench for uart_host_ctrl with a small register-slave model.
module tb_uart_host_ctrl;

    logic        clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic [2:0]  wb_addr_o;
    logic [7:0]  wb_dat_o;
    logic        wb_we_o, wb_re_o;
    logic [7:0]  wb_dat_i;
    logic        int_i = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_div = '0;
    logic [6:0]  cfg_lcr = '0;
    logic [7:0]  cfg_fcr = '0;
    logic [3:0]  cfg_ier = '0;
    logic        cfg_done, busy;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  lsr_o, msr_o;
    logic        lsr_stb, msr_stb;

    // Slave register contents seen by reads.
    logic [7:0]  iir_v = 8'hC1, rb_v = '0, lsr_v = '0, msr_v = '0;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Monitor state.
    int          wr_addr[$];
    logic [7:0]  wr_dat[$];
    logic        wr_done[$];
    int          rd_addr[$];
    int          rd_cyc[$];
    int          cyc = 0;
    int          n_stb = 0, n_done = 0, n_lsr = 0, n_msr = 0, n_viol = 0;
    bit          prev_stb = 1'b0;

    always #5 clk = ~clk;

    uart_host_ctrl #(
        .ADDR_W    (3),
        .TX_DEPTH  (16),
        .INT_SETTLE(2)
    ) dut (
        .clk      (clk),
        .wb_rst_n (wb_rst_n),
        .wb_addr_o(wb_addr_o),
        .wb_dat_o (wb_dat_o),
        .wb_we_o  (wb_we_o),
        .wb_re_o  (wb_re_o),
        .wb_dat_i (wb_dat_i),
        .int_i    (int_i),
        .cfg_start(cfg_start),
        .cfg_div  (cfg_div),
        .cfg_lcr  (cfg_lcr),
        .cfg_fcr  (cfg_fcr),
        .cfg_ier  (cfg_ier),
        .cfg_done (cfg_done),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .lsr_o    (lsr_o),
        .lsr_stb  (lsr_stb),
        .msr_o    (msr_o),
        .msr_stb  (msr_stb)
    );

    function automatic logic [7:0] slave_val(input logic [2:0] a);
        case (a)
            3'd0:    return rb_v;
            3'd2:    return iir_v;
            3'd5:    return lsr_v;
            3'd6:    return msr_v;
            default: return 8'h00;
        endcase
    endfunction

    // Registered read data: valid only in the cycle after the read strobe.
    initial begin
        logic [7:0] rd_val;
        wb_dat_i = 8'h00;
        forever begin
            @(negedge clk);
            if (wb_re_o === 1'b1) begin
                rd_val = slave_val(wb_addr_o);
                @(posedge clk);
                #1 wb_dat_i = rd_val;
                @(posedge clk);
                #1 wb_dat_i = 8'h00;
            end
        end
    end

    // Bus monitor: logs accesses and counts strobe-spacing violations.
    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_stb <= (wb_we_o === 1'b1) || (wb_re_o === 1'b1);
        if (wb_we_o === 1'b1) begin
            wr_addr.push_back(int'(wb_addr_o));
            wr_dat.push_back(wb_dat_o);
            wr_done.push_back(cfg_done);
        end
        if (wb_re_o === 1'b1) begin
            rd_addr.push_back(int'(wb_addr_o));
            rd_cyc.push_back(cyc);
        end
        if ((wb_we_o === 1'b1) || (wb_re_o === 1'b1)) n_stb <= n_stb + 1;
        if (cfg_done === 1'b1) n_done <= n_done + 1;
        if (lsr_stb === 1'b1) n_lsr <= n_lsr + 1;
        if (msr_stb === 1'b1) n_msr <= n_msr + 1;
        if ((((wb_we_o === 1'b1) || (wb_re_o === 1'b1)) && prev_stb) ||
            ((wb_we_o === 1'b1) && (wb_re_o === 1'b1)))
            n_viol <= n_viol + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_re(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (wb_re_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic do_cfg(input logic [15:0] d, input logic [6:0] l, input logic [7:0] f,
                          input logic [3:0] e);
        cfg_div   = d;
        cfg_lcr   = l;
        cfg_fcr   = f;
        cfg_ier   = e;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if ({wb_we_o, wb_re_o, cfg_done, tx_ready} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b want 0000", {wb_we_o, wb_re_o, cfg_done, tx_ready});
        end
        n_cmp++;
        if ({busy, rx_valid, lsr_stb, msr_stb} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000", {busy, rx_valid, lsr_stb, msr_stb});
        end
        n_cmp++;
        if ({wb_addr_o, wb_dat_o} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got addr %h dat %h want 0 0", wb_addr_o, wb_dat_o);
        end
        n_cmp++;
        if ({lsr_o, msr_o} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_status: got lsr %h msr %h want 0 0", lsr_o, msr_o);
        end
        tick();
        wb_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cfg();
        int         exp_a[6] = '{3, 0, 1, 3, 2, 1};
        logic [7:0] exp_d[6] = '{8'h83, 8'h45, 8'h01, 8'h03, 8'hC0, 8'h0F};
        int         w0, d0;
        bit         ok;
        w0 = wr_addr.size();
        d0 = n_done;
        do_cfg(16'h0145, 7'h03, 8'hC0, 4'hF);
        wait_idle(30, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL cfg_timeout: busy stuck, want idle"); end
        n_cmp++;
        if (wr_addr.size() != w0 + 6) begin
            n_bad++;
            $display("FAIL cfg_count: got %0d writes want 6", wr_addr.size() - w0);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (w0 + i >= wr_addr.size()) begin
                n_bad++;
                $display("FAIL cfg_wr%0d: missing want (%0d,%h)", i, exp_a[i], exp_d[i]);
            end else if (wr_addr[w0 + i] != exp_a[i] || wr_dat[w0 + i] !== exp_d[i]) begin
                n_bad++;
                $display("FAIL cfg_wr%0d: got (%0d,%h) want (%0d,%h)", i, wr_addr[w0 + i],
                         wr_dat[w0 + i], exp_a[i], exp_d[i]);
            end
        end
        n_cmp++;
        if (w0 + 5 >= wr_done.size() || wr_done[w0 + 5] !== 1'b1 || n_done - d0 != 1) begin
            n_bad++;
            $display("FAIL cfg_done: got %0d pulses want 1 on 6th write", n_done - d0);
        end
    endtask

    task automatic test_tx();
        int w0, r0, n_acc, errs;
        bit got, ok;
        w0 = wr_addr.size();
        r0 = rd_addr.size();
        n_acc = 0;
        for (int i = 0; i < 17; i++) begin
            tx_data  = 8'h10 + 8'(i);
            tx_valid = 1'b1;
            got      = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                got = (tx_ready === 1'b1);
                tick();
            end
            if (got) n_acc++;
        end
        n_cmp++;
        if (n_acc != 16) begin
            n_bad++;
            $display("FAIL tx_credit_stall: got %0d accepted want 16", n_acc);
        end
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            if (w0 + i >= wr_addr.size()) errs++;
            else if (wr_addr[w0 + i] != 0 || wr_dat[w0 + i] !== 8'h10 + 8'(i)) errs++;
        end
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL tx_writes: got %0d bad THR writes want 0", errs);
        end
        // THRE interrupt refills credits; the stalled byte goes out afterwards.
        iir_v = 8'hC2;
        int_i = 1'b1;
        wait_re(10, ok);
        tick();
        int_i = 1'b0;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL tx_thre_read: no IIR read want one"); end
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            got = (tx_ready === 1'b1);
            tick();
        end
        tx_valid = 1'b0;
        n_cmp++;
        if (!got || wr_dat.size() != w0 + 17 || wr_dat[wr_dat.size() - 1] !== 8'h20) begin
            n_bad++;
            $display("FAIL tx_17th: got accepted=%0d writes=%0d want 1 and 17 (last 20)", got,
                     wr_dat.size() - w0);
        end
        n_cmp++;
        if (rd_addr.size() != r0 + 1 || rd_addr[r0] != 2) begin
            n_bad++;
            $display("FAIL tx_thre_reads: got %0d reads want 1 of II", rd_addr.size() - r0);
        end
    endtask

    task automatic test_rx();
        int r0, s0;
        bit ok, seen;
        r0 = rd_addr.size();
        iir_v = 8'hC4;
        rb_v  = 8'hA5;
        int_i = 1'b1;
        wait_re(10, ok);
        tick();
        int_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            seen = (rx_valid === 1'b1);
            tick();
        end
        n_cmp++;
        if (!ok || !seen) begin
            n_bad++;
            $display("FAIL rx_arrive: got ii=%0d valid=%0d want 1 1", ok, seen);
        end
        s0 = n_stb;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({rx_valid, rx_data} !== {1'b1, 8'hA5}) begin
                n_bad++;
                $display("FAIL rx_hold%0d: got v=%b d=%h want 1 A5", c, rx_valid, rx_data);
            end
            tick();
        end
        n_cmp++;
        if (n_stb != s0) begin
            n_bad++;
            $display("FAIL rx_quiet: got %0d strobes while held want 0", n_stb - s0);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_release: got rx_valid %b want 0", rx_valid);
        end
        tick();
        n_cmp++;
        if (rd_addr.size() != r0 + 2 || rd_addr[r0] != 2 || rd_addr[r0 + 1] != 0) begin
            n_bad++;
            $display("FAIL rx_reads: got %0d reads want II then RB", rd_addr.size() - r0);
        end
        repeat (4) tick();
    endtask

    task automatic test_lsr_msr();
        int         r0, cnt, l0;
        logic [7:0] cap;
        bit         ok;
        // Line-status service.
        r0 = rd_addr.size();
        iir_v = 8'hC6;
        lsr_v = 8'h61;
        int_i = 1'b1;
        wait_re(10, ok);
        tick();
        int_i = 1'b0;
        cnt = 0;
        cap = 8'h00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (lsr_stb === 1'b1) begin cnt++; cap = lsr_o; end
            tick();
        end
        n_cmp++;
        if (cnt != 1 || cap !== 8'h61) begin
            n_bad++;
            $display("FAIL lsr_service: got %0d pulses lsr %h want 1 61", cnt, cap);
        end
        n_cmp++;
        if (lsr_o !== 8'h61) begin
            n_bad++;
            $display("FAIL lsr_held: got %h want 61", lsr_o);
        end
        n_cmp++;
        if (rd_addr.size() != r0 + 2 || rd_addr[r0 + 1] != 5) begin
            n_bad++;
            $display("FAIL lsr_reads: got %0d reads want II then LS", rd_addr.size() - r0);
        end
        // Modem-status service.
        r0 = rd_addr.size();
        l0 = n_lsr;
        iir_v = 8'hC0;
        msr_v = 8'hB3;
        int_i = 1'b1;
        wait_re(10, ok);
        tick();
        int_i = 1'b0;
        cnt = 0;
        cap = 8'h00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (msr_stb === 1'b1) begin cnt++; cap = msr_o; end
            tick();
        end
        n_cmp++;
        if (cnt != 1 || cap !== 8'hB3) begin
            n_bad++;
            $display("FAIL msr_service: got %0d pulses msr %h want 1 B3", cnt, cap);
        end
        n_cmp++;
        if (rd_addr.size() != r0 + 2 || rd_addr[r0 + 1] != 6 || n_lsr != l0) begin
            n_bad++;
            $display("FAIL msr_reads: got %0d reads, %0d lsr pulses want II,MS and 0",
                     rd_addr.size() - r0, n_lsr - l0);
        end
    endtask

    task automatic test_reset_mid_cfg();
        int         w0, nw, s0;
        bit         ok;
        logic [7:0] d3;
        w0 = wr_addr.size();
        do_cfg(16'h1234, 7'h1B, 8'h07, 4'h5);
        nw = 0;
        ok = 1'b0;
        d3 = 8'h00;
        for (int c = 0; c < 12 && !ok; c++) begin
            @(negedge clk);
            if (wb_we_o === 1'b1) begin
                nw++;
                if (nw == 3) begin
                    ok = 1'b1;
                    d3 = wb_dat_o;
                    wb_rst_n = 1'b0;
                end
            end
        end
        n_cmp++;
        if (!ok || d3 !== 8'h12) begin
            n_bad++;
            $display("FAIL rst_third_write: got seen=%0d dat %h want 1 12", ok, d3);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({busy, wb_we_o, wb_re_o, wb_addr_o, wb_dat_o} !== 14'h0) begin
            n_bad++;
            $display("FAIL rst_idle: got busy %b we %b re %b addr %h dat %h want all 0",
                     busy, wb_we_o, wb_re_o, wb_addr_o, wb_dat_o);
        end
        n_cmp++;
        if ({lsr_o, msr_o} !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_status: got lsr %h msr %h want 0 0", lsr_o, msr_o);
        end
        tick();
        wb_rst_n = 1'b1;
        // Unconfigured: neither tx_valid nor int_i may start an access.
        s0 = n_stb;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        int_i    = 1'b1;
        repeat (10) tick();
        tx_valid = 1'b0;
        int_i    = 1'b0;
        tick();
        n_cmp++;
        if (n_stb != s0) begin
            n_bad++;
            $display("FAIL rst_unconfigured: got %0d strobes want 0", n_stb - s0);
        end
        n_cmp++;
        if (wr_addr.size() != w0 + 3) begin
            n_bad++;
            $display("FAIL rst_no_replay: got %0d writes want 3", wr_addr.size() - w0);
        end
    endtask

    task automatic test_int_noop();
        int r0, s0;
        bit ok, ok2;
        logic b3, b4;
        do_cfg(16'h0145, 7'h03, 8'hC0, 4'hF);
        wait_idle(30, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL noop_cfg: busy stuck want idle"); end
        // Phase 1: single no-op service, int_i dropped after the IIR read.
        r0 = rd_addr.size();
        iir_v = 8'hC1;
        int_i = 1'b1;
        wait_re(10, ok);
        tick();
        int_i = 1'b0;
        s0 = n_stb;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        b3 = busy;
        tick();
        @(negedge clk);
        b4 = busy;
        tick();
        n_cmp++;
        if (!ok || n_stb != s0) begin
            n_bad++;
            $display("FAIL noop_quiet: got ii=%0d extra strobes %0d want 1 0", ok, n_stb - s0);
        end
        n_cmp++;
        if ({b3, b4} !== 2'b10) begin
            n_bad++;
            $display("FAIL noop_settle: got busy %b%b at +3/+4 want 10", b3, b4);
        end
        n_cmp++;
        if (rd_addr.size() != r0 + 1) begin
            n_bad++;
            $display("FAIL noop_reads: got %0d reads want 1", rd_addr.size() - r0);
        end
        // Phase 2: int_i held; next IIR read only after gap + settle + idle.
        r0 = rd_cyc.size();
        int_i = 1'b1;
        wait_re(10, ok);
        wait_re(10, ok2);
        tick();
        int_i = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (!ok || !ok2 || rd_cyc.size() < r0 + 2) begin
            n_bad++;
            $display("FAIL noop_repeat: got %0d reads want 2", rd_cyc.size() - r0);
        end else if (rd_cyc[r0 + 1] - rd_cyc[r0] != 5) begin
            n_bad++;
            $display("FAIL noop_repeat: got spacing %0d want 5", rd_cyc[r0 + 1] - rd_cyc[r0]);
        end
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_tx();
        test_rx();
        test_lsr_msr();
        test_reset_mid_cfg();
        test_int_noop();
        n_cmp++;
        if (n_viol != 0) begin
            n_bad++;
            $display("FAIL strobe_spacing: got %0d violations want 0", n_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
